// File: rtl/fifo_flex_pkg.sv
// Shared types and default-threshold helpers for the fifo_flex block.
package fifo_flex_pkg;

    // Read-port behaviour: registered word after the pop, or head word shown combinationally
    typedef enum logic {
        RD_REGISTERED = 1'b0,
        RD_FWFT       = 1'b1
    } rd_mode_e;

    // Almost-full default: two below full, never below one entry
    function automatic int default_afull_thresh(input int depth_bits);
        int depth;
        depth = 1 << depth_bits;
        return (depth > 2) ? depth - 2 : depth;
    endfunction

    // Almost-empty default: two entries, clipped so it stays below DEPTH
    function automatic int default_aempty_thresh(input int depth_bits);
        int depth;
        depth = 1 << depth_bits;
        return (depth - 1 < 2) ? depth - 1 : 2;
    endfunction

endpackage

// File: rtl/fifo_flex_mem.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one asynchronous read port.
module fifo_flex_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_BITS = 4
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [DEPTH_BITS-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [DEPTH_BITS-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int DEPTH = 1 << DEPTH_BITS;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Store the write word; contents are not reset, occupancy tracking makes stale words invisible
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_flex.sv
// Single-clock FIFO with selectable FWFT/registered read, thresholds, level, flush and sticky errors.
module fifo_flex
    import fifo_flex_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH_BITS    = 4,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = default_afull_thresh(DEPTH_BITS),
    parameter int AEMPTY_THRESH = default_aempty_thresh(DEPTH_BITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  clr_err,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [DEPTH_BITS:0]   level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam int LW    = DEPTH_BITS + 1;

    localparam logic [LW-1:0]         LVL_ONE  = LW'(1);
    localparam logic [LW-1:0]         LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0]         LVL_AF   = LW'(AFULL_THRESH);
    localparam logic [LW-1:0]         LVL_AE   = LW'(AEMPTY_THRESH);
    localparam logic [DEPTH_BITS-1:0] PTR_ONE  = DEPTH_BITS'(1);
    localparam rd_mode_e              RD_MODE  = (FWFT != 0) ? RD_FWFT : RD_REGISTERED;

    // Threshold ranges are checked at elaboration so a bad instance never builds
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $error("fifo_flex: AFULL_THRESH out of range 1..DEPTH");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
        $error("fifo_flex: AEMPTY_THRESH out of range 0..DEPTH-1");
    end

    logic [DEPTH_BITS-1:0] r_wr_ptr;
    logic [DEPTH_BITS-1:0] r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_acc_rd;
    logic                  w_acc_wr;
    logic                  w_ovf_evt;
    logic                  w_unf_evt;
    logic [DATA_WIDTH-1:0] w_mem_rdata;

    // Status is decoded from the registered level only, so it never depends on this cycle's requests
    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LVL_FULL);

    // A read frees a slot in the same cycle, which lets a write into a full FIFO proceed.
    // Flush masks both requests so they are neither accepted nor flagged as errors.
    assign w_acc_rd  = !flush && rd_en && !w_empty;
    assign w_acc_wr  = !flush && wr_en && (!w_full || w_acc_rd);
    assign w_ovf_evt = !flush && wr_en && !w_acc_wr;
    assign w_unf_evt = !flush && rd_en && !w_acc_rd;

    fifo_flex_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_BITS (DEPTH_BITS)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_acc_wr),
        .i_waddr (r_wr_ptr),
        .i_wdata (data_in),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_mem_rdata)
    );

    // Pointers advance on accepted transfers and wrap modulo DEPTH by width
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_acc_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_acc_rd) r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Occupancy: a simultaneous push and pop leaves it unchanged
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_level <= '0;
        end else begin
            case ({w_acc_wr, w_acc_rd})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Sticky error flags: a new event in the clearing cycle wins, flush leaves them alone
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (r_overflow  && !clr_err) || w_ovf_evt;
            r_underflow <= (r_underflow && !clr_err) || w_unf_evt;
        end
    end

    if (RD_MODE == RD_FWFT) begin : g_fwft
        // Head word is shown directly; it is meaningless while empty
        assign data_out = w_mem_rdata;
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] r_data_out;

        // Registered read: capture the head on the popping edge, otherwise hold
        always_ff @(posedge clk) begin
            if (rst || flush) begin
                r_data_out <= '0;
            end else if (w_acc_rd) begin
                r_data_out <= w_mem_rdata;
            end
        end

        assign data_out = r_data_out;
    end

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_level >= LVL_AF);
    assign almost_empty = (r_level <= LVL_AE);
    assign level        = r_level;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_flex.sv
// Bench for fifo_flex: a registered-read and an FWFT instance share one stimulus stream,
// a queue model predicts every output each cycle, and directed literals pin key points.
module tb_fifo_flex;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic       clr_err = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       rd_en = 1'b0;

    logic [7:0] dout_r, dout_f;
    logic       full_r, empty_r, af_r, ae_r, ovf_r, unf_r;
    logic       full_f, empty_f, af_f, ae_f, ovf_f, unf_f;
    logic [4:0] lvl_r, lvl_f;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    fifo_flex #(.DATA_WIDTH(8), .DEPTH_BITS(4), .FWFT(0)) dut_reg (
        .clk(clk), .rst(rst), .flush(flush), .clr_err(clr_err),
        .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(dout_r), .full(full_r), .empty(empty_r),
        .almost_full(af_r), .almost_empty(ae_r), .level(lvl_r),
        .overflow(ovf_r), .underflow(unf_r)
    );

    fifo_flex #(.DATA_WIDTH(8), .DEPTH_BITS(4), .FWFT(1)) dut_fw (
        .clk(clk), .rst(rst), .flush(flush), .clr_err(clr_err),
        .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(dout_f), .full(full_f), .empty(empty_f),
        .almost_full(af_f), .almost_empty(ae_f), .level(lvl_f),
        .overflow(ovf_f), .underflow(unf_f)
    );

    // Behavioural model: a queue of words plus flags, stepped on every rising edge
    logic [7:0] q[$];
    logic [7:0] m_dreg = 8'h00;
    bit         m_ovf = 1'b0;
    bit         m_unf = 1'b0;

    always @(posedge clk) begin
        bit ard, awr, nov, nun;
        ard = 1'b0; awr = 1'b0; nov = 1'b0; nun = 1'b0;
        if (rst) begin
            q.delete();
            m_dreg = 8'h00;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (flush) begin
                q.delete();
                m_dreg = 8'h00;
            end else begin
                ard = rd_en && (q.size() > 0);
                awr = wr_en && ((q.size() < 16) || ard);
                nov = wr_en && !awr;
                nun = rd_en && !ard;
                if (ard) m_dreg = q.pop_front();
                if (awr) q.push_back(data_in);
            end
            m_ovf = (m_ovf && !clr_err) || nov;
            m_unf = (m_unf && !clr_err) || nun;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model, away from the rising edge
    always @(negedge clk) begin
        if (chk_en) begin
            int sz;
            sz = q.size();
            chk("lvl_r",   32'(lvl_r),   32'(sz));
            chk("lvl_f",   32'(lvl_f),   32'(sz));
            chk("empty_r", 32'(empty_r), 32'(sz == 0));
            chk("empty_f", 32'(empty_f), 32'(sz == 0));
            chk("full_r",  32'(full_r),  32'(sz == 16));
            chk("full_f",  32'(full_f),  32'(sz == 16));
            chk("af_r",    32'(af_r),    32'(sz >= 14));
            chk("af_f",    32'(af_f),    32'(sz >= 14));
            chk("ae_r",    32'(ae_r),    32'(sz <= 2));
            chk("ae_f",    32'(ae_f),    32'(sz <= 2));
            chk("ovf_r",   32'(ovf_r),   32'(m_ovf));
            chk("ovf_f",   32'(ovf_f),   32'(m_ovf));
            chk("unf_r",   32'(unf_r),   32'(m_unf));
            chk("unf_f",   32'(unf_f),   32'(m_unf));
            chk("dout_r",  32'(dout_r),  32'(m_dreg));
            if (sz > 0) chk("dout_f", 32'(dout_f), 32'(q[0]));
        end
    end

    // Drive one cycle of inputs at the falling edge, return at the next falling edge
    task automatic step(input bit w, input logic [7:0] d, input bit r,
                        input bit fl = 1'b0, input bit ce = 1'b0, input bit rs = 1'b0);
        wr_en = w; data_in = d; rd_en = r; flush = fl; clr_err = ce; rst = rs;
        @(negedge clk);
    endtask

    initial begin
        int maxlvl;
        @(negedge clk);

        // Reset, with a write attempt that reset must override
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;
        chk("rst_level", 32'(lvl_r), 32'd0);
        chk("rst_empty", 32'(empty_r), 32'd1);
        chk("rst_ae", 32'(ae_r), 32'd1);
        chk("rst_full", 32'(full_r), 32'd0);
        chk("rst_dout", 32'(dout_r), 32'h00);

        // Fill 0x00..0x0F; almost_full appears once level reaches 14
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i), 1'b0);
            if (i == 12) chk("af_at13", 32'(af_r), 32'd0);
            if (i == 13) chk("af_at14", 32'(af_r), 32'd1);
        end
        chk("fill_full", 32'(full_r), 32'd1);
        chk("fill_level", 32'(lvl_r), 32'd16);

        // 17th write is rejected
        step(1'b1, 8'h99, 1'b0);
        chk("ovf_set", 32'(ovf_r), 32'd1);
        chk("ovf_level", 32'(lvl_f), 32'd16);

        // Drain in order, then one read too many
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00, 1'b1);
            if (i == 0) chk("drain_first", 32'(dout_r), 32'h00);
        end
        chk("drain_last", 32'(dout_r), 32'h0F);
        chk("drain_empty", 32'(empty_r), 32'd1);
        step(1'b0, 8'h00, 1'b1);
        chk("unf_set", 32'(unf_r), 32'd1);
        chk("unf_hold", 32'(dout_r), 32'h0F);

        // Clear coinciding with a new underflow: the set wins
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("unf_setwins", 32'(unf_r), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("err_clear", 32'(ovf_r | unf_r), 32'd0);

        // FWFT single word: visible the cycle after the write, gone the cycle after the pop
        step(1'b1, 8'hA5, 1'b0);
        chk("fwft_head", 32'(dout_f), 32'hA5);
        chk("fwft_nempty", 32'(empty_f), 32'd0);
        step(1'b0, 8'h00, 1'b1);
        chk("fwft_empty", 32'(empty_f), 32'd1);
        chk("reg_a5", 32'(dout_r), 32'hA5);

        // Empty with read and write together: write lands, read flagged
        step(1'b1, 8'h3C, 1'b1);
        chk("ew_level", 32'(lvl_r), 32'd1);
        chk("ew_unf", 32'(unf_r), 32'd1);
        chk("ew_head", 32'(dout_f), 32'h3C);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        // Full with read and write together: oldest word out, 0x55 queued at the tail
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
        step(1'b1, 8'h55, 1'b1);
        chk("fs_dout", 32'(dout_r), 32'h10);
        chk("fs_level", 32'(lvl_r), 32'd16);
        chk("fs_noovf", 32'(ovf_r), 32'd0);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
        chk("fs_tail", 32'(dout_r), 32'h55);

        // Wrap-around: prefill 3, then 40 write/read pairs with random data
        maxlvl = 0;
        for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
            if (int'(lvl_r) > maxlvl) maxlvl = int'(lvl_r);
            step(1'b0, 8'h00, 1'b1);
            if (int'(lvl_r) > maxlvl) maxlvl = int'(lvl_r);
        end
        chk("wrap_max4", 32'(maxlvl), 32'd4);

        // Flush at level 9 with a write and an earlier overflow pending
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1);
        chk("pre_flush_lvl", 32'(lvl_r), 32'd9);
        step(1'b1, 8'h77, 1'b0, 1'b1);
        chk("flush_level", 32'(lvl_r), 32'd0);
        chk("flush_empty", 32'(empty_f), 32'd1);
        chk("flush_ovf", 32'(ovf_r), 32'd1);
        chk("flush_dout", 32'(dout_r), 32'h00);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("clr_ovf", 32'(ovf_r), 32'd0);

        // Pointers restart from zero after the flush
        step(1'b1, 8'hC3, 1'b0);
        chk("post_flush_head", 32'(dout_f), 32'hC3);
        step(1'b0, 8'h00, 1'b1);
        chk("post_flush_rd", 32'(dout_r), 32'hC3);

        step(1'b0, 8'h00, 1'b0);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
